// File: rtl/ddr_package.sv
// rtl/ddr_package.sv - shared types and constants for the DDR read-return capture path
package ddr_package;

    localparam int DIMM_ADDR_W = 29;
    localparam int DATA_W      = 64;
    localparam int BL8_PAIRS   = 4;
    localparam int BC4_PAIRS   = 2;

    typedef logic [DIMM_ADDR_W-1:0] dimm_addr_type;
    typedef logic [DATA_W-1:0]      data_type;

    typedef struct packed {
        dimm_addr_type addr;
        bit            bl8;
    } rd_req_t;

    typedef enum logic {
        CAP_IDLE = 1'b0,
        CAP_BUSY = 1'b1
    } cap_state_t;

    // Index of the final beat pair of a burst of the given length.
    function automatic logic [1:0] last_pair(input logic bl8);
        return bl8 ? 2'(BL8_PAIRS - 1) : 2'(BC4_PAIRS - 1);
    endfunction

endpackage

// File: rtl/ddr_rd_tag_fifo.sv
// rtl/ddr_rd_tag_fifo.sv - sync FIFO of outstanding read requests (address + burst length)
module ddr_rd_tag_fifo
    import ddr_package::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clock_t,
    input  logic                   reset_n,
    input  logic                   push_i,
    input  rd_req_t                push_data_i,
    input  logic                   pop_i,
    output rd_req_t                head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    rd_req_t       mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          push_ok, pop_ok;

    // Pointers carry one extra MSB so full and empty differ only in that bit.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // A pop frees the slot a same-cycle push into a full FIFO needs.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Pointer next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers.
    always_ff @(posedge clock_t) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clock_t) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/ddr_rd_capture.sv
// rtl/ddr_rd_capture.sv - read-return capture top; optional DBI inversion via DDR_RD_DBI_EN
module ddr_rd_capture
    import ddr_package::*;
#(
    parameter int RL    = 11,
    parameter int DEPTH = 8,
    parameter int DQ_W  = 8
) (
    input  logic                   clock_t,
    input  logic                   reset_n,
    input  logic                   rd_cmd_valid,
    input  logic [28:0]            rd_cmd_addr,
    input  logic                   rd_cmd_bl8,
    input  logic [DQ_W-1:0]        dq_r,
    input  logic [DQ_W-1:0]        dq_f,
`ifdef DDR_RD_DBI_EN
    input  logic                   dbi_r_n,
    input  logic                   dbi_f_n,
`endif
    output logic                   rd_valid,
    output logic [28:0]            rd_addr,
    output logic [63:0]            rd_data,
    output logic                   rd_bl8,
    output logic [$clog2(DEPTH):0] outstanding,
    output logic                   err_ovf,
    output logic                   err_orphan,
    output logic                   err_overlap
);

    localparam int OW = $clog2(DEPTH) + 1;

    logic [DQ_W-1:0] beat_r, beat_f;
    logic            cmd_accept, strobe;
    logic            fifo_full, fifo_empty;
    rd_req_t         fifo_head;
    logic [OW-1:0]   fifo_count;
    logic            cap_last;
    data_type        cap_merged;

    logic [RL-2:0]   dl_q, dl_d;
    cap_state_t      state_q, state_d;
    logic [1:0]      pair_q, pair_d;
    rd_req_t         act_q, act_d;
    data_type        cap_q, cap_d;
    logic            rd_valid_q, rd_valid_d;
    dimm_addr_type   rd_addr_q, rd_addr_d;
    data_type        rd_data_q, rd_data_d;
    logic            rd_bl8_q, rd_bl8_d;
    logic            err_ovf_q, err_ovf_d;
    logic            err_orphan_q, err_orphan_d;
    logic            err_overlap_q, err_overlap_d;

`ifdef DDR_RD_DBI_EN
    assign beat_r = dbi_r_n ? dq_r : ~dq_r;
    assign beat_f = dbi_f_n ? dq_f : ~dq_f;
`else
    assign beat_r = dq_r;
    assign beat_f = dq_f;
`endif

    // Last delay-line stage fires one cycle before the first beat pair lands.
    assign strobe     = dl_q[RL-2];
    // A full FIFO still takes a command when the strobe pops an entry this cycle.
    assign cmd_accept = rd_cmd_valid && (!fifo_full || strobe);
    assign cap_last   = (state_q == CAP_BUSY) && (pair_q == last_pair(act_q.bl8));

    ddr_rd_tag_fifo #(
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clock_t     (clock_t),
        .reset_n     (reset_n),
        .push_i      (cmd_accept),
        .push_data_i ('{addr: rd_cmd_addr, bl8: rd_cmd_bl8}),
        .pop_i       (strobe),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Shift accepted commands toward the burst-start tap; length rides in the FIFO entry.
    always_comb begin
        dl_d    = dl_q;
        dl_d[0] = cmd_accept;
        for (int i = 1; i < RL - 1; i++) dl_d[i] = dl_q[i-1];
    end

    // Current capture buffer with this cycle's beat pair dropped into its slot.
    always_comb begin
        cap_merged = cap_q;
        for (int k = 0; k < BL8_PAIRS; k++) begin
            if (pair_q == 2'(k)) begin
                cap_merged[k*2*DQ_W +: DQ_W]        = beat_r;
                cap_merged[k*2*DQ_W + DQ_W +: DQ_W] = beat_f;
            end
        end
    end

    // Capture FSM: count beat pairs, publish on the last one, restart on each strobe.
    always_comb begin
        state_d       = state_q;
        pair_d        = pair_q;
        act_d         = act_q;
        cap_d         = cap_q;
        rd_valid_d    = 1'b0;
        rd_addr_d     = rd_addr_q;
        rd_data_d     = rd_data_q;
        rd_bl8_d      = rd_bl8_q;
        err_orphan_d  = err_orphan_q;
        err_overlap_d = err_overlap_q;
        err_ovf_d     = err_ovf_q | (rd_cmd_valid & ~cmd_accept);

        if (state_q == CAP_BUSY) begin
            if (cap_last) begin
                rd_valid_d = 1'b1;
                rd_addr_d  = act_q.addr;
                rd_data_d  = cap_merged;
                rd_bl8_d   = act_q.bl8;
                state_d    = CAP_IDLE;
            end else if (strobe) begin
                err_overlap_d = 1'b1;
            end else begin
                pair_d = pair_q + 2'd1;
                cap_d  = cap_merged;
            end
        end

        if (strobe) begin
            if (!fifo_empty) begin
                state_d = CAP_BUSY;
                act_d   = fifo_head;
                pair_d  = '0;
                cap_d   = '0;
            end else begin
                state_d      = CAP_IDLE;
                err_orphan_d = 1'b1;
            end
        end
    end

    // State, capture and output registers; reset drops everything in flight.
    always_ff @(posedge clock_t) begin
        if (!reset_n) begin
            dl_q          <= '0;
            state_q       <= CAP_IDLE;
            pair_q        <= '0;
            act_q         <= '0;
            cap_q         <= '0;
            rd_valid_q    <= 1'b0;
            rd_addr_q     <= '0;
            rd_data_q     <= '0;
            rd_bl8_q      <= 1'b0;
            err_ovf_q     <= 1'b0;
            err_orphan_q  <= 1'b0;
            err_overlap_q <= 1'b0;
        end else begin
            dl_q          <= dl_d;
            state_q       <= state_d;
            pair_q        <= pair_d;
            act_q         <= act_d;
            cap_q         <= cap_d;
            rd_valid_q    <= rd_valid_d;
            rd_addr_q     <= rd_addr_d;
            rd_data_q     <= rd_data_d;
            rd_bl8_q      <= rd_bl8_d;
            err_ovf_q     <= err_ovf_d;
            err_orphan_q  <= err_orphan_d;
            err_overlap_q <= err_overlap_d;
        end
    end

    assign rd_valid    = rd_valid_q;
    assign rd_addr     = rd_addr_q;
    assign rd_data     = rd_data_q;
    assign rd_bl8      = rd_bl8_q;
    assign outstanding = fifo_count + OW'(state_q == CAP_BUSY);
    assign err_ovf     = err_ovf_q;
    assign err_orphan  = err_orphan_q;
    assign err_overlap = err_overlap_q;

endmodule

// File: tb/tb_ddr_rd_capture.sv
// tb/tb_ddr_rd_capture.sv - directed bench with queue-based read-return model
module tb_ddr_rd_capture;

    localparam int RL    = 11;
    localparam int DEPTH = 8;
    localparam int DQ_W  = 8;
    localparam int OW    = $clog2(DEPTH) + 1;
    localparam int NC    = 1024;

    logic          clock_t = 1'b0;
    logic          reset_n;
    logic          rd_cmd_valid;
    logic [28:0]   rd_cmd_addr;
    logic          rd_cmd_bl8;
    logic [7:0]    dq_r, dq_f;
    logic          rd_valid;
    logic [28:0]   rd_addr;
    logic [63:0]   rd_data;
    logic          rd_bl8;
    logic [OW-1:0] outstanding;
    logic          err_ovf, err_orphan, err_overlap;
`ifdef DDR_RD_DBI_EN
    logic          dbi_r_n, dbi_f_n;
`endif

    ddr_rd_capture #(.RL(RL), .DEPTH(DEPTH), .DQ_W(DQ_W)) dut (
        .clock_t      (clock_t),
        .reset_n      (reset_n),
        .rd_cmd_valid (rd_cmd_valid),
        .rd_cmd_addr  (rd_cmd_addr),
        .rd_cmd_bl8   (rd_cmd_bl8),
        .dq_r         (dq_r),
        .dq_f         (dq_f),
`ifdef DDR_RD_DBI_EN
        .dbi_r_n      (dbi_r_n),
        .dbi_f_n      (dbi_f_n),
`endif
        .rd_valid     (rd_valid),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_bl8       (rd_bl8),
        .outstanding  (outstanding),
        .err_ovf      (err_ovf),
        .err_orphan   (err_orphan),
        .err_overlap  (err_overlap)
    );

    always #5 clock_t = ~clock_t;

    // Per-cycle stimulus tables.
    logic        t_rn [NC];
    logic        t_cv [NC];
    logic [28:0] t_ca [NC];
    logic        t_cb [NC];
    logic [7:0]  t_br [NC];
    logic [7:0]  t_bf [NC];
`ifdef DDR_RD_DBI_EN
    logic        t_dr [NC];
    logic        t_df [NC];
`endif

    // Model state.
    typedef struct {
        logic [28:0] addr;
        logic        bl8;
    } req_t;
    req_t        m_q [$];
    bit          m_sched [NC + 64];
    bit          m_act;
    req_t        m_cur;
    int          m_start;
    logic [63:0] m_data;

    logic        e_valid, e_bl8, e_ovf, e_orphan, e_overlap;
    logic [28:0] e_addr;
    logic [63:0] e_data;
    int          e_out;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          cmp_en = 0;
    int          pulses = 0;
    logic [28:0] p_addr [$];
    int          p_cyc [$];
    logic [63:0] last_data;
    logic        last_bl8;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual %h required %h", name, cyc, act, exp);
        end
    endtask

    // Outputs expected after the clock edge that consumes cycle c's inputs.
    task automatic model_step(input int c);
        logic [7:0] r, f;
        int k, n;
        req_t nr;
        r = t_br[c];
        f = t_bf[c];
`ifdef DDR_RD_DBI_EN
        if (!t_dr[c]) r = ~r;
        if (!t_df[c]) f = ~f;
`endif
        if (!t_rn[c]) begin
            m_q.delete();
            foreach (m_sched[i]) m_sched[i] = 0;
            m_act = 0;
            e_valid = 0; e_bl8 = 0; e_addr = '0; e_data = '0;
            e_ovf = 0; e_orphan = 0; e_overlap = 0; e_out = 0;
            return;
        end
        e_valid = 0;
        if (m_act && c >= m_start) begin
            k = c - m_start;
            m_data[16*k +: 8]     = r;
            m_data[16*k + 8 +: 8] = f;
            n = m_cur.bl8 ? 4 : 2;
            if (k == n - 1) begin
                e_valid = 1;
                e_addr  = m_cur.addr;
                e_data  = m_data;
                e_bl8   = m_cur.bl8;
                m_act   = 0;
            end
        end
        if (m_sched[c + 1]) begin
            m_sched[c + 1] = 0;
            if (m_act) begin
                e_overlap = 1;
                m_act = 0;
            end
            if (m_q.size() > 0) begin
                m_cur   = m_q.pop_front();
                m_act   = 1;
                m_start = c + 1;
                m_data  = '0;
            end else begin
                e_orphan = 1;
            end
        end
        if (t_cv[c]) begin
            if (m_q.size() < DEPTH) begin
                nr.addr = t_ca[c];
                nr.bl8  = t_cb[c];
                m_q.push_back(nr);
                m_sched[c + RL] = 1;
            end else begin
                e_ovf = 1;
            end
        end
        e_out = m_q.size() + (m_act ? 1 : 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            reset_n      = t_rn[cyc];
            rd_cmd_valid = t_cv[cyc];
            rd_cmd_addr  = t_ca[cyc];
            rd_cmd_bl8   = t_cb[cyc];
            dq_r         = t_br[cyc];
            dq_f         = t_bf[cyc];
`ifdef DDR_RD_DBI_EN
            dbi_r_n      = t_dr[cyc];
            dbi_f_n      = t_df[cyc];
`endif
            model_step(cyc);
            cmp_en = 1;
            cyc++;
            @(negedge clock_t);
            #1;
        end
    endtask

    task automatic cmd(input int c, input logic [28:0] a, input logic b);
        t_cv[c] = 1'b1;
        t_ca[c] = a;
        t_cb[c] = b;
    endtask

    task automatic beats(input int s, input logic [63:0] d, input int np);
        for (int k = 0; k < np; k++) begin
            t_br[s + k] = d[16*k +: 8];
            t_bf[s + k] = d[16*k + 8 +: 8];
        end
    endtask

    // Every-cycle comparison against the model, plus a log of completed bursts.
    always @(negedge clock_t) begin
        if (cmp_en) begin
            chk("rd_valid",    64'(rd_valid),    64'(e_valid));
            chk("rd_addr",     64'(rd_addr),     64'(e_addr));
            chk("rd_data",     rd_data,          e_data);
            chk("rd_bl8",      64'(rd_bl8),      64'(e_bl8));
            chk("outstanding", 64'(outstanding), 64'(e_out));
            chk("err_ovf",     64'(err_ovf),     64'(e_ovf));
            chk("err_orphan",  64'(err_orphan),  64'(e_orphan));
            chk("err_overlap", 64'(err_overlap), 64'(e_overlap));
            if (rd_valid === 1'b1) begin
                pulses++;
                p_addr.push_back(rd_addr);
                p_cyc.push_back(cyc);
                last_data = rd_data;
                last_bl8  = rd_bl8;
            end
        end
    end

    initial begin
        int t, p0;
        for (int c = 0; c < NC; c++) begin
            t_rn[c] = 1'b1;
            t_cv[c] = 1'b0;
            t_ca[c] = 29'($urandom);
            t_cb[c] = 1'b0;
            t_br[c] = 8'($urandom);
            t_bf[c] = 8'($urandom);
`ifdef DDR_RD_DBI_EN
            t_dr[c] = 1'b1;
            t_df[c] = 1'b1;
`endif
        end
        t_rn[0] = 1'b0;
        t_rn[1] = 1'b0;
        run(3);
        chk("reset_outstanding", 64'(outstanding), 64'd0);
        chk("reset_rd_valid",    64'(rd_valid),    64'd0);
        chk("reset_rd_data",     rd_data,          64'd0);

        // 1: single BL8
        t = cyc + 1; p0 = pulses;
        cmd(t, 29'h0000123, 1'b1);
        beats(t + RL, 64'h8877665544332211, 4);
        run(RL + 8);
        chk("t1_count",   64'(pulses - p0),     64'd1);
        chk("t1_data",    last_data,            64'h8877665544332211);
        chk("t1_addr",    64'(p_addr[$]),       64'h123);
        chk("t1_bl8",     64'(last_bl8),        64'd1);
        chk("t1_latency", 64'(p_cyc[$] - t),    64'(RL + 4));

        // 2: single BC4 at top address
        t = cyc + 1; p0 = pulses;
        cmd(t, 29'h1FFFFFFF, 1'b0);
        beats(t + RL, 64'h00000000D4C3B2A1, 2);
        run(RL + 6);
        chk("t2_count",   64'(pulses - p0),     64'd1);
        chk("t2_data",    last_data,            64'h00000000D4C3B2A1);
        chk("t2_addr",    64'(p_addr[$]),       64'h1FFFFFFF);
        chk("t2_latency", 64'(p_cyc[$] - t),    64'(RL + 2));

        // 3: two BL8 four cycles apart, back-to-back capture
        t = cyc + 1; p0 = pulses;
        cmd(t,     29'h0000AAA, 1'b1);
        cmd(t + 4, 29'h0000BBB, 1'b1);
        beats(t + RL,     64'h0102030405060708, 4);
        beats(t + 4 + RL, 64'h1112131415161718, 4);
        run(RL + 12);
        chk("t3_count",   64'(pulses - p0),            64'd2);
        chk("t3_addr0",   64'(p_addr[$-1]),            64'hAAA);
        chk("t3_addr1",   64'(p_addr[$]),              64'hBBB);
        chk("t3_gap",     64'(p_cyc[$] - p_cyc[$-1]),  64'd4);
        chk("t3_errs",    64'({err_ovf, err_orphan, err_overlap}), 64'd0);

        t_rn[cyc] = 1'b0;
        run(2);

        // 4: DEPTH+1 back-to-back commands overflow the FIFO
        t = cyc + 1; p0 = pulses;
        for (int i = 0; i <= DEPTH; i++) cmd(t + i, 29'(32'h100 + i), 1'b1);
        run(DEPTH + 2);
        chk("t4_full",     64'(outstanding), 64'(DEPTH));
        chk("t4_ovf",      64'(err_ovf),     64'd1);
        run(RL + 16);
        chk("t4_overlap",  64'(err_overlap), 64'd1);
        chk("t4_count",    64'(pulses - p0), 64'd1);
        chk("t4_last",     64'(p_addr[$]),   64'h107);

        t_rn[cyc] = 1'b0;
        run(2);

        // 5: BC4 two cycles after a BL8 abandons the BL8
        t = cyc + 1; p0 = pulses;
        cmd(t,     29'h0000C0C, 1'b1);
        cmd(t + 2, 29'h0000D0D, 1'b0);
        beats(t + 2 + RL, 64'h000000009A9B9C9D, 2);
        run(RL + 10);
        chk("t5_overlap",  64'(err_overlap),    64'd1);
        chk("t5_count",    64'(pulses - p0),    64'd1);
        chk("t5_addr",     64'(p_addr[$]),      64'hD0D);
        chk("t5_data",     last_data,           64'h000000009A9B9C9D);
        chk("t5_latency",  64'(p_cyc[$] - t),   64'(RL + 4));

        t_rn[cyc] = 1'b0;
        run(2);

        // 6: reset in the middle of a BL8 burst
        t = cyc + 1; p0 = pulses;
        cmd(t, 29'h0000EEE, 1'b1);
        beats(t + RL, 64'h2122232425262728, 4);
        t_rn[t + RL + 2] = 1'b0;
        run(RL + 8);
        chk("t6_count",       64'(pulses - p0), 64'd0);
        chk("t6_outstanding", 64'(outstanding), 64'd0);
        chk("t6_rd_data",     rd_data,          64'd0);
        chk("t6_rd_addr",     64'(rd_addr),     64'd0);

`ifdef DDR_RD_DBI_EN
        // 7: inverted first even beat
        t = cyc + 1; p0 = pulses;
        cmd(t, 29'h0000123, 1'b1);
        beats(t + RL, 64'h8877665544332211, 4);
        t_dr[t + RL] = 1'b0;
        run(RL + 8);
        chk("t7_count", 64'(pulses - p0), 64'd1);
        chk("t7_data",  last_data,        64'h88776655443322EE);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
